// File: rtl/softmax_normalize.sv
// Softmax normalizer: buffers N exponentials, then emits each divided by
// their sum using a restoring shift-subtract divider, one bit per cycle.
module softmax_normalize #(
  parameter int N          = 10,
  parameter int DATA_WIDTH = 20,
  parameter int FRAC_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         in_valid,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic signed [DATA_WIDTH-1:0] out_data,
  output logic [3:0]                   out_index,
  output logic                         done
);

  localparam int QW = DATA_WIDTH + FRAC_WIDTH;
  localparam int SW = DATA_WIDTH + 4;
  localparam int BW = $clog2(QW);

  localparam logic [4:0]    LAST_CNT = 5'(N - 1);
  localparam logic [3:0]    LAST_IDX = 4'(N - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(QW - 1);

  typedef enum logic [1:0] {
    LOAD,
    DIVIDE,
    EMIT,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [DATA_WIDTH-1:0] mem [16];
  logic [SW-1:0]         sum;
  logic [SW-1:0]         rem;
  logic [4:0]            count;
  logic [3:0]            idx;
  logic [BW-1:0]         bcnt;
  logic [DATA_WIDTH-1:0] quo;

  logic [DATA_WIDTH-1:0] sample;
  logic [QW-1:0]         dvd;
  logic                  dbit;
  logic [SW:0]           trial;
  logic                  take;
  logic                  capture;

  assign sample   = in_data[DATA_WIDTH-1] ? '0 : in_data;
  assign in_ready = (state == LOAD);
  assign capture  = in_ready && in_valid;

  // Dividend bits fed MSB first: buf[idx] << FRAC_WIDTH
  assign dvd   = {mem[idx], {FRAC_WIDTH{1'b0}}};
  assign dbit  = dvd[LAST_BIT - bcnt];
  assign trial = {rem, dbit};
  assign take  = (trial >= {1'b0, sum});

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= LOAD;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      LOAD: begin
        if (capture && count == LAST_CNT) begin
          state_nx = DIVIDE;
        end
      end
      DIVIDE: begin
        if (bcnt == LAST_BIT) begin
          state_nx = EMIT;
        end
      end
      EMIT: begin
        state_nx = (idx == LAST_IDX) ? FIN : DIVIDE;
      end
      FIN: begin
        state_nx = LOAD;
      end
      default: state_nx = LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      mem[count[3:0]] <= sample;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum       <= '0;
      count     <= '0;
      idx       <= '0;
      bcnt      <= '0;
      rem       <= '0;
      quo       <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        LOAD: begin
          if (in_valid) begin
            sum   <= sum + SW'(sample);
            count <= count + 5'd1;
            idx   <= '0;
            bcnt  <= '0;
            rem   <= '0;
            quo   <= '0;
          end
        end
        DIVIDE: begin
          rem  <= take ? SW'(trial - {1'b0, sum})
                       : trial[SW-1:0];
          quo  <= {quo[DATA_WIDTH-2:0], take};
          bcnt <= bcnt + 1'b1;
        end
        EMIT: begin
          out_valid <= 1'b1;
          // A zero sum would make every trial succeed; force zero.
          out_data  <= (sum == '0) ? '0 : quo;
          out_index <= idx;
          idx       <= idx + 4'd1;
          bcnt      <= '0;
          rem       <= '0;
          quo       <= '0;
        end
        FIN: begin
          done  <= 1'b1;
          sum   <= '0;
          count <= '0;
          idx   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_normalize.sv
// Self-checking bench for softmax_normalize (N=4): directed and random
// batches compared against an arithmetic reference model.
module tb_softmax_normalize;

  localparam int N  = 4;
  localparam int DW = 20;
  localparam int P  = 31;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic [3:0]           out_index;
  logic                 done;

  int checks   = 0;
  int failures = 0;

  softmax_normalize #(
    .N         (N),
    .DATA_WIDTH(DW),
    .FRAC_WIDTH(10)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_index(out_index),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic longint clampv(input logic [DW-1:0] x);
    return x[DW-1] ? 64'd0 : longint'(x);
  endfunction

  function automatic logic [31:0] ref_q(input logic [DW-1:0] x[N],
                                        input int k);
    longint s = 0;
    for (int i = 0; i < N; i++) s += clampv(x[i]);
    if (s == 0) return 32'd0;
    return 32'((clampv(x[k]) * 1024) / s);
  endfunction

  task automatic run_batch(input logic [DW-1:0] x[N], input bit hold);
    logic [31:0] exp_q [N];
    for (int i = 0; i < N; i++) exp_q[i] = ref_q(x, i);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = x[i];
      chk("in_ready_load", {31'd0, in_ready}, 32'd1);
      cyc();
    end
    in_valid = hold;
    in_data  = DW'($urandom);
    for (int t = 1; t <= P * N + 1; t++) begin
      bit ov;
      cyc();
      if (hold) in_data = DW'($urandom);
      ov = (t % P == 0) && (t <= P * N);
      chk("out_valid", {31'd0, out_valid}, {31'd0, ov});
      if (ov) begin
        chk("out_data", {12'd0, out_data}, exp_q[t / P - 1]);
        chk("out_index", {28'd0, out_index}, 32'(t / P - 1));
      end
      chk("done", {31'd0, done}, {31'd0, t == P * N + 1});
      chk("in_ready", {31'd0, in_ready}, {31'd0, t == P * N + 1});
    end
    in_valid = 1'b0;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_out_data", {12'd0, out_data}, 32'd0);
    chk("rst_out_index", {28'd0, out_index}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    logic [DW-1:0] b [N];
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    cyc();
    cyc();
    chk_reset_state();
    reset = 1'b0;
    cyc();
    chk_reset_state();

    b = '{20'h00400, 20'h00400, 20'h00400, 20'h00400};
    run_batch(b, 1'b0);
    b = '{20'h00C00, 20'h00400, 20'h00000, 20'h00000};
    run_batch(b, 1'b0);
    b = '{20'h7FFFF, 20'h00001, 20'h00001, 20'h00001};
    run_batch(b, 1'b0);
    b = '{20'hFFC00, 20'h00400, 20'h00400, 20'h00000};
    run_batch(b, 1'b0);
    b = '{20'h00000, 20'h00000, 20'h00000, 20'h00000};
    run_batch(b, 1'b0);
    b = '{20'h00800, 20'h00400, 20'h00200, 20'h00200};
    run_batch(b, 1'b1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        case ($urandom % 4)
          0: b[i] = DW'($urandom) | 20'h80000;
          1: b[i] = DW'($urandom_range(0, 16));
          default: b[i] = DW'($urandom_range(0, 20'h7FFFF));
        endcase
      end
      run_batch(b, r[0]);
    end

    // Abort a batch while dividing element 1
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_data  = 20'h00C00;
      cyc();
    end
    in_valid = 1'b0;
    for (int t = 0; t < P + 10; t++) cyc();
    reset = 1'b1;
    cyc();
    chk_reset_state();
    reset = 1'b0;
    for (int t = 0; t < 4 * P + 10; t++) begin
      cyc();
      chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
      chk("abort_done", {31'd0, done}, 32'd0);
    end

    b = '{20'h00400, 20'h00400, 20'h00400, 20'h00400};
    run_batch(b, 1'b0);
    run_batch(b, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/softmax_normalize.md
SOFTMAX_NORMALIZE -- requirements
Module: softmax_normalize

Interface
REQ-001 Parameter N, default 10: number of exponential values per batch; legal range 2..16.
REQ-002 Parameter DATA_WIDTH, default 20: width of input and output words; both are Q10.10.
REQ-003 Parameter FRAC_WIDTH, default 10: fraction bits of input and output.
REQ-004 clk  input  1: single clock; all logic on rising edge.
REQ-005 reset  input  1: synchronous, active-high reset.
REQ-006 in_valid  input  1: in_data holds a valid exponential result this cycle.
REQ-007 in_data  input  DATA_WIDTH signed: exponential output, Q10.10.
REQ-008 in_ready  output  1: block accepts in_data this cycle.
REQ-009 out_valid  output  1: one-cycle strobe; out_data and out_index are valid.
REQ-010 out_data  output  DATA_WIDTH signed: normalized probability, Q10.10, range 0..1.0 (0x00000..0x00400).
REQ-011 out_index  output  4: position (0..N-1) of the element in its batch.
REQ-012 done  output  1: one-cycle pulse after the last element of a batch is emitted.

Function
REQ-013 The FSM SHALL have states LOAD, DIVIDE, EMIT and FIN; the reset state is LOAD.
REQ-014 LOAD: in_ready=1; an in_valid cycle stores the sample in buffer slot count, adds it to sum and increments count.
REQ-015 On capture, a negative in_data (sign bit set) SHALL be stored and summed as 0.
REQ-016 The sum register SHALL be DATA_WIDTH+4 bits unsigned, so 16 maximum inputs cannot overflow.
REQ-017 On the cycle the Nth sample is accepted, the FSM SHALL go LOAD->DIVIDE with idx=0; in_ready SHALL be 0 in every state except LOAD.
REQ-018 DIVIDE: restoring shift-subtract of dividend buf[idx]<<FRAC_WIDTH by sum, one quotient bit per cycle, for exactly DATA_WIDTH+FRAC_WIDTH (30) cycles, then go to EMIT.
REQ-019 The quotient SHALL be floor(buf[idx]*2^FRAC_WIDTH / sum), zero-extended to DATA_WIDTH; the result never exceeds 0x00400.
REQ-020 If sum==0, every element's quotient SHALL be 0; the 30-cycle DIVIDE timing SHALL be kept.
REQ-021 EMIT: out_valid=1 for exactly one cycle with out_data=quotient and out_index=idx; then idx increments.
REQ-022 From EMIT, the FSM SHALL go to DIVIDE if idx<N-1, otherwise to FIN.
REQ-023 FIN: done=1 for one cycle; sum, count and idx are cleared; then go to LOAD, so in_ready=1 on the next cycle.
REQ-024 Latency: with edge E0 capturing the Nth sample, element k's out_valid SHALL be high in the cycle following edge E0+31*(k+1).
REQ-025 done SHALL be high in the cycle after the last out_valid cycle.
REQ-026 in_valid while in_ready=0 SHALL be ignored: no capture, no state change.
REQ-027 out_data, out_index and the buffer SHALL hold their last values when not updated; out_valid and done are 0 except as stated above.

Reset
REQ-028 While reset=1 at a clock edge: state=LOAD, count=0, sum=0, idx=0, out_valid=0, done=0, out_data=0, out_index=0; in_ready=1 after the edge.
REQ-029 Reset mid-batch (any state) SHALL abort the batch: no further out_valid or done for it, and the next batch SHALL compute correctly.
REQ-030 Buffer contents need not be cleared by reset.

Verification
REQ-031 N=4, inputs 0x00400 x4 -> out_data 0x00100 at idx 0..3, spaced 31 cycles, then done pulse.
REQ-032 N=4, inputs 3.0, 1.0, 0, 0 (0x00C00, 0x00400, 0, 0) -> 0x00300, 0x00100, 0, 0.
REQ-033 N=4, inputs 0x7FFFF, 1, 1, 1 -> 0x003FF, 0, 0, 0; confirms no sum overflow and truncation.
REQ-034 N=4, inputs 0xFFC00 (-1.0), 0x00400, 0x00400, 0 -> 0, 0x00200, 0x00200, 0; all-zero batch -> four zero outputs with normal timing.
REQ-035 Reset asserted during DIVIDE of idx 1 -> no further out_valid or done; back-to-back batch of 0x00400 x4 -> 0x00100 x4.
REQ-036 in_valid held high through DIVIDE/EMIT/FIN -> ignored; exactly N samples taken per batch, and the next batch starts in the cycle after FIN.
